// File: rtl/apu_pkg.sv
// Shared APU constants: frame-sequencer timing, mode encodings and $4017 bit layout.
// Pure definitions, no logic; imported by the sequencer and the channel blocks.
package apu_pkg;

  localparam int STEP_DIV_NTSC = 7457;

  typedef enum logic {
    SEQ_MODE_4STEP = 1'b0,
    SEQ_MODE_5STEP = 1'b1
  } seq_mode_t;

  localparam int SEQ_STEPS_4 = 4;
  localparam int SEQ_STEPS_5 = 5;

  localparam int REG4017_MODE_BIT    = 7;
  localparam int REG4017_INHIBIT_BIT = 6;

  // Returns {quarter, half} strobe request for a given mode and step.
  function automatic logic [1:0] step_action(input seq_mode_t mode, input logic [2:0] idx);
    logic [1:0] act;
    act = 2'b00;
    case (idx)
      3'd0: act = 2'b10;
      3'd1: act = 2'b11;
      3'd2: act = 2'b10;
      3'd3: act = (mode == SEQ_MODE_4STEP) ? 2'b11 : 2'b00;
      3'd4: act = (mode == SEQ_MODE_5STEP) ? 2'b11 : 2'b00;
      default: act = 2'b00;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/apu_frame_sequencer_toggle_sync.sv
// Two-flop synchroniser for a toggle change flag plus edge detect -> one-cycle pulse.
// Pulse is high in the cycle after the second sync flop captures the new level; no backpressure.
module toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic tog,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= tog;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 ^ prev;

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: quarter/half-frame strobes and frame IRQ, configured through $4017.
// Register write takes effect 3 edges after the toggle; strobes registered; no backpressure.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int STEP_DIV = STEP_DIV_NTSC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] reg_4017,
  input  logic       reg_4017_change,
  input  logic       irq_ack,
  output logic       enable_240hz,
  output logic       enable_120hz,
  output logic       frame_irq,
  output logic [2:0] step_index
);

  localparam logic [15:0] PRESCALE_LAST = 16'(STEP_DIV - 1);
  localparam logic [2:0]  LAST_STEP_4   = 3'(SEQ_STEPS_4 - 1);
  localparam logic [2:0]  LAST_STEP_5   = 3'(SEQ_STEPS_5 - 1);

  logic        write_evt;
  seq_mode_t   mode;
  logic        inhibit;
  logic [15:0] prescaler;
  logic        irq_pend;

  seq_mode_t   wr_mode;
  logic        wr_inhibit;
  logic        expiry;
  logic [1:0]  act;
  logic [2:0]  last_step;
  logic        unused_bits;

  toggle_sync u_toggle_sync (
    .clk   (clk),
    .rst   (rst),
    .tog   (reg_4017_change),
    .pulse (write_evt)
  );

  assign wr_mode     = seq_mode_t'(reg_4017[REG4017_MODE_BIT]);
  assign wr_inhibit  = reg_4017[REG4017_INHIBIT_BIT];
  assign unused_bits = ^reg_4017[5:0];
  assign expiry      = (prescaler == PRESCALE_LAST);
  assign act         = step_action(mode, step_index);
  assign last_step   = (mode == SEQ_MODE_5STEP) ? LAST_STEP_5 : LAST_STEP_4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode         <= SEQ_MODE_4STEP;
      inhibit      <= 1'b0;
      prescaler    <= 16'd0;
      step_index   <= 3'd0;
      enable_240hz <= 1'b0;
      enable_120hz <= 1'b0;
      irq_pend     <= 1'b0;
      frame_irq    <= 1'b0;
    end else begin
      enable_240hz <= 1'b0;
      enable_120hz <= 1'b0;
      irq_pend     <= 1'b0;

      // A register write wins over a step expiring in the same cycle.
      if (write_evt) begin
        mode       <= wr_mode;
        inhibit    <= wr_inhibit;
        prescaler  <= 16'd0;
        step_index <= 3'd0;
        if (wr_mode == SEQ_MODE_5STEP) begin
          enable_240hz <= 1'b1;
          enable_120hz <= 1'b1;
        end
      end else if (expiry) begin
        prescaler    <= 16'd0;
        enable_240hz <= act[1];
        enable_120hz <= act[0];
        step_index   <= (step_index == last_step) ? 3'd0 : step_index + 3'd1;
        irq_pend     <= (mode == SEQ_MODE_4STEP) && (step_index == LAST_STEP_4) && !inhibit;
      end else begin
        prescaler <= prescaler + 16'd1;
      end

      // IRQ rises the cycle after the step-3 strobe; a set beats a coincident ack.
      if (write_evt && wr_inhibit) begin
        frame_irq <= 1'b0;
      end else if (irq_pend) begin
        frame_irq <= 1'b1;
      end else if (irq_ack) begin
        frame_irq <= 1'b0;
      end
    end
  end

endmodule
